sobel_grad_post: RTL
====================

# sobel_grad_post

Parametrised output stage for the Sobel edge-detection chain. It takes gradient magnitude and normalised angle from the CORDIC stage and produces an 8-bit edge pixel in one of four modes, including a frame-adaptive binary threshold computed from the previous frame's mean magnitude. It also produces a 2-bit quantised gradient direction for downstream non-maximum suppression. It sits directly after `cordic_top` and replaces the combinational clip/binarise logic at the Sobel top level.

## Interface
- `MW`, 16, input magnitude width
- `DW`, 8, output pixel width; full scale is `2^DW-1`
- `AW`, 20, angle width; the angle is normalised as α/(2π)·2^AW
- `SW`, 32, frame-sum and divider width
- `CW`, 24, pixel-count width; saturates
- `GAIN`, 6, adaptive threshold scale in quarter units; threshold = mean·GAIN/4
- `THR_MIN`, 16, floor applied to the adaptive threshold
- `THR_INIT`, 128, adaptive threshold value after reset
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous reset, active low
- `din_vsync`  in  1  frame valid, active high
- `din_hsync`  in  1  line valid / pixel valid, active high
- `din_mag`  in  MW  gradient magnitude, unsigned
- `din_angle`  in  AW  gradient angle, normalised
- `mode`  in  2  0 = clip, 1 = binary with manual threshold, 2 = binary with adaptive threshold, 3 = zero pixels below manual threshold and clip the rest
- `thr_manual`  in  DW  manual threshold
- `dout_vsync`  out  1  `din_vsync` delayed by 2 cycles
- `dout_hsync`  out  1  `din_hsync` delayed by 2 cycles
- `dout`  out  DW  edge pixel
- `dout_dir`  out  2  0 = 0°, 1 = 45°, 2 = 90°, 3 = 135° (taken mod 180°)
- `frame_thr`  out  DW  threshold currently applied (manual or adaptive, according to the latched mode)
- `stat_busy`  out  1  high while the mean divider runs

## Operation
- **Clip:** `magc = (din_mag > 2^DW-1) ? 2^DW-1 : din_mag[DW-1:0]`.
- **Direction:**
  - `a = din_angle + 2^(AW-4)` mod 2^AW, i.e. the angle plus 22.5°.
  - `dout_dir = a[AW-2:AW-3]`, i.e. the low 2 bits of the octant index `a[AW-1:AW-3]`.
- **Frame-start latch:** on the `din_vsync` rising edge, `mode` and `thr_manual` are latched. The adaptive threshold register is copied into the active threshold on the same edge. Input changes mid-frame have no effect until the next frame.
- **Output by latched mode:**
  - Mode 0: `magc`.
  - Modes 1 and 2: all ones if `magc >= thr`, else 0.
  - Mode 3: `magc` if `magc >= thr_manual`, else 0.
- When the delayed hsync is low, `dout` and `dout_dir` are 0.
- **Statistics accumulation:**
  - Counted only while `din_vsync & din_hsync`.
  - `sum += magc`, saturating at `2^SW-1`.
  - `cnt += 1`, saturating at `2^CW-1`.
- **Frame end (`din_vsync` falling edge):**
  - Snapshot `sum` and `cnt` into the divider registers, then clear the accumulators.
  - If `cnt == 0`, skip the divider; the adaptive threshold is unchanged.
- **Divider state machine:**
  - IDLE → DIV on a snapshot with `cnt != 0`.
  - DIV: restoring division, one quotient bit per cycle, SW cycles; then → SCALE.
  - SCALE, 1 cycle:
    - `t = (mean·GAIN) >> 2`.
    - Clip `t` to `2^DW-1`, then apply the floor: `max(t, THR_MIN)`.
    - Write the result to the adaptive threshold register, then → IDLE.
- **Snapshot while busy:** if a new frame-end snapshot arrives while in DIV or SCALE (blanking shorter than SW+1 cycles), restart DIV with the new snapshot. The in-progress result is discarded.
- **Late result:** if the divider finishes after the next `din_vsync` rising edge, the new value applies from the frame after.
- `frame_thr` shows the active threshold: `thr_manual` latched when the latched mode is not 2, the adaptive active threshold when it is 2.

## Timing
- Latency is 2 cycles from input to all `dout_*` outputs.
  - Stage 1 registers `magc`, the direction and the syncs.
  - Stage 2 registers the thresholded pixel.
- Throughput is one pixel per clock, with no backpressure.
- The adaptive update completes SW+1 cycles after the `din_vsync` falling edge, or immediately (no update) if `cnt == 0`.
- Frame start and frame end are detected from a 1-cycle registered copy of `din_vsync`.
- **Reset (asynchronous, at any time including mid-frame):**
  - All outputs go to 0, with `frame_thr = THR_INIT` when the reset mode is 0 (the latched mode resets to 0, so `frame_thr` shows `thr_manual`, reset to THR_INIT).
  - Adaptive and active thresholds = THR_INIT.
  - Accumulators cleared; divider in IDLE; `stat_busy` = 0.
  - The first frame after reset starts cleanly on the next `din_vsync` rising edge.

## Test plan
- **Mode 0, magnitude clipping:** `din_mag` = 300, then 100 → `dout` = 255, then 100, each appearing 2 cycles after input; `dout_hsync` aligned with the data.
- **Mode 1, manual threshold:** `thr_manual` = 128, `din_mag` = 127 / 128 / 129 → 0 / 255 / 255. Change `thr_manual` to 200 mid-frame → no effect until the next frame.
- **Direction quantisation:**
  - angle 0x00000 → 0
  - angle 0x0FFFF → 0
  - angle 0x10000 → 1
  - angle 0x20000 (45°) → 1
  - angle 0x40000 (90°) → 2
  - angle 0x60000 (135°) → 3
  - angle 0x80000 (180°) → 0
  - angle 0xFFFFF → 0
- **Adaptive threshold (mode 2):**
  - Frame A: 16 valid pixels, each of magnitude 40, then `din_vsync` falls → `stat_busy` high for 33 cycles, adaptive threshold = 60.
  - Frame B: `frame_thr` = 60 after the `din_vsync` rising edge; magnitude 59 → 0, 60 → 255.
- **Adaptive boundary cases:**
  - A frame with no valid pixels → threshold unchanged.
  - Mean 2 → threshold clamped to THR_MIN = 16.
  - Mean 255 → threshold clipped to 255.
  - A second frame end after only 10 cycles of blanking → divider restarts; the final threshold reflects only the second frame.
- **Reset mid-frame and mid-divide:** assert `rst_n` low while `stat_busy` is high → all outputs 0 immediately, `stat_busy` = 0. After release, the next frame in mode 2 uses threshold 128.

Source files
------------

// File: rtl/sobel_grad_post.sv
// Sobel output stage: clips or thresholds the gradient magnitude, quantises the gradient
// direction, and derives a frame-adaptive threshold from the previous frame's mean magnitude.
module sobel_grad_post #(
    parameter int MW       = 16,
    parameter int DW       = 8,
    parameter int AW       = 20,
    parameter int SW       = 32,
    parameter int CW       = 24,
    parameter int GAIN     = 6,
    parameter int THR_MIN  = 16,
    parameter int THR_INIT = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din_vsync,
    input  logic          din_hsync,
    input  logic [MW-1:0] din_mag,
    input  logic [AW-1:0] din_angle,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] thr_manual,
    output logic          dout_vsync,
    output logic          dout_hsync,
    output logic [DW-1:0] dout,
    output logic [1:0]    dout_dir,
    output logic [DW-1:0] frame_thr,
    output logic          stat_busy
);
    localparam int               CNT_W     = $clog2(SW);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SW - 1);
    localparam logic [DW-1:0]    PIX_MAX   = {DW{1'b1}};
    localparam logic [DW-1:0]    THR_FLOOR = DW'(THR_MIN);
    localparam logic [DW-1:0]    THR_RST   = DW'(THR_INIT);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_SCALE} state_t;
    state_t state, state_nx;

    logic             vs_q, hs_q;
    logic             frame_start, frame_end, snap;
    logic [DW-1:0]    magc, magc_q;
    logic [1:0]       dir, dir_q;
    logic [1:0]       mode_q;
    logic [DW-1:0]    thr_man_q, thr_act, thr_adapt, thr_sel, pix;
    logic [SW-1:0]    sum;
    logic [SW:0]      sum_ext;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    rem, quo, den;
    logic [SW:0]      rem_sh, rem_sub;
    logic             rem_ge;
    logic [CNT_W-1:0] step_cnt;
    logic [SW+3:0]    scaled;
    logic [SW+1:0]    t_quarter;
    logic [DW-1:0]    t_clip, thr_new;
    logic             unused_bits;

    assign frame_start = din_vsync & ~vs_q;
    assign frame_end   = ~din_vsync & vs_q;
    assign snap        = frame_end && (cnt != '0);

    assign magc = (din_mag > {{(MW-DW){1'b0}}, PIX_MAX}) ? PIX_MAX : din_mag[DW-1:0];
    // Adding 22.5 deg carries into the folded octant bits only when bit AW-4 is set.
    assign dir  = din_angle[AW-2:AW-3] + {1'b0, din_angle[AW-4]};

    assign unused_bits = ^{din_angle[AW-1], din_angle[AW-5:0], scaled[1:0]};

    // NOTE: every register sits in an async-reset always_ff with non-blocking assignments
    // so all stages sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            magc_q    <= '0;
            dir_q     <= '0;
            mode_q    <= '0;
            thr_man_q <= THR_RST;
            thr_act   <= THR_RST;
        end else begin
            vs_q   <= din_vsync;
            hs_q   <= din_hsync;
            magc_q <= magc;
            dir_q  <= dir;
            if (frame_start) begin
                mode_q    <= mode;
                thr_man_q <= thr_manual;
                thr_act   <= thr_adapt;
            end
        end
    end

    assign thr_sel   = (mode_q == 2'd2) ? thr_act : thr_man_q;
    assign frame_thr = thr_sel;

    // NOTE: pix gets a default before the case so no path can infer a latch.
    always_comb begin
        pix = magc_q;
        case (mode_q)
            2'd0:       pix = magc_q;
            2'd1, 2'd2: pix = (magc_q >= thr_sel) ? PIX_MAX : '0;
            default:    pix = (magc_q >= thr_man_q) ? magc_q : '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_vsync <= 1'b0;
            dout_hsync <= 1'b0;
            dout       <= '0;
            dout_dir   <= '0;
        end else begin
            dout_vsync <= vs_q;
            dout_hsync <= hs_q;
            dout       <= hs_q ? pix : '0;
            dout_dir   <= hs_q ? dir_q : '0;
        end
    end

    assign sum_ext = {1'b0, sum} + {{(SW+1-DW){1'b0}}, magc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            cnt <= '0;
        end else if (frame_end) begin
            sum <= '0;
            cnt <= '0;
        end else if (din_vsync && din_hsync) begin
            sum <= sum_ext[SW] ? {SW{1'b1}} : sum_ext[SW-1:0];
            cnt <= (&cnt) ? cnt : cnt + CW'(1);
        end
    end

    // Restoring division: the dividend shifts out of quo while quotient bits shift in.
    assign rem_sh  = {rem, quo[SW-1]};
    assign rem_sub = rem_sh - {1'b0, den};
    assign rem_ge  = ~rem_sub[SW];

    assign scaled    = {4'b0000, quo} * (SW+4)'(GAIN);
    assign t_quarter = scaled[SW+3:2];
    assign t_clip    = (t_quarter > {{(SW+2-DW){1'b0}}, PIX_MAX}) ? PIX_MAX : t_quarter[DW-1:0];
    assign thr_new   = (t_clip < THR_FLOOR) ? THR_FLOOR : t_clip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (snap) state_nx = S_DIV;
            S_DIV:   if (!snap && step_cnt == LAST_STEP) state_nx = S_SCALE;
            S_SCALE: state_nx = snap ? S_DIV : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem       <= '0;
            quo       <= '0;
            den       <= '0;
            step_cnt  <= '0;
            thr_adapt <= THR_RST;
        end else if (snap) begin
            rem      <= '0;
            quo      <= sum;
            den      <= {{(SW-CW){1'b0}}, cnt};
            step_cnt <= '0;
        end else if (state == S_DIV) begin
            rem      <= rem_ge ? rem_sub[SW-1:0] : rem_sh[SW-1:0];
            quo      <= {quo[SW-2:0], rem_ge};
            step_cnt <= step_cnt + CNT_W'(1);
        end else if (state == S_SCALE) begin
            thr_adapt <= thr_new;
        end
    end

    assign stat_busy = (state != S_IDLE);

endmodule
